// File: rtl/enigma_disp_pkg.sv
// enigma_disp_pkg: shared segment constants, letter/digit types and the 7-seg glyph table.
package enigma_disp_pkg;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;
    localparam logic [4:0] LETTER_MAX = 5'd26;

    typedef logic [4:0] letter_t;
    typedef logic [1:0] digit_sel_t;
    typedef enum logic {ST_BLANK, ST_DRIVE} slot_state_t;

    // Active-low glyphs, bit0=a .. bit6=g
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 7'h40;
            4'd1:    digit_glyph = 7'h79;
            4'd2:    digit_glyph = 7'h24;
            4'd3:    digit_glyph = 7'h30;
            4'd4:    digit_glyph = 7'h19;
            4'd5:    digit_glyph = 7'h12;
            4'd6:    digit_glyph = 7'h02;
            4'd7:    digit_glyph = 7'h78;
            4'd8:    digit_glyph = 7'h00;
            4'd9:    digit_glyph = 7'h10;
            default: digit_glyph = SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/letter_seg_decoder.sv
// letter_seg_decoder: letter code 0..26 to tens/units glyphs; out-of-range codes show dashes.
module letter_seg_decoder
    import enigma_disp_pkg::*;
(
    input  letter_t    code_i,
    output logic [6:0] tens_o,
    output logic [6:0] units_o
);
    logic [1:0] tens;
    logic [3:0] units;
    always_comb begin
        tens    = code_i >= 5'd20 ? 2'd2 : code_i >= 5'd10 ? 2'd1 : 2'd0;
        units   = 4'(code_i - 5'(tens) * 5'd10);
        tens_o  = code_i > LETTER_MAX ? SEG_DASH : digit_glyph({2'b00, tens});
        units_o = code_i > LETTER_MAX ? SEG_DASH : digit_glyph(units);
    end
endmodule

// File: rtl/enigma_display_scanner.sv
// enigma_display_scanner: 4-digit multiplexed letter display with frame-aligned updates.
// Optional blink of the cipher pair after each update when DISP_BLINK_EN is defined.
module enigma_display_scanner
    import enigma_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd_valid,
    output logic       upd_ready,
    input  logic [4:0] upd_plain,
    input  logic [4:0] upd_cipher,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    digit_sel_t    digit_q, digit_d;
    slot_state_t   state_q, state_d;
    logic          pending_q, pending_d;
    letter_t       shadow_plain_q, shadow_plain_d, shadow_cipher_q, shadow_cipher_d;
    letter_t       act_plain_q, act_plain_d, act_cipher_q, act_cipher_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          wrap, boundary, accept, dark;
    letter_t       dec_code;
    logic [6:0]    dec_tens, dec_units;

    letter_seg_decoder u_dec (
        .code_i  (dec_code),
        .tens_o  (dec_tens),
        .units_o (dec_units)
    );

    always_comb begin
        wrap            = slot_cnt_q == CW'(REFRESH_DIV - 1);
        boundary        = wrap && digit_q == 2'd0;
        accept          = upd_valid && !pending_q;
        slot_cnt_d      = wrap ? '0 : slot_cnt_q + CW'(1);
        digit_d         = wrap ? digit_q - 2'd1 : digit_q;
        state_d         = slot_cnt_d < CW'(BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;
        // A handshake on the boundary cycle lands in shadow and waits a full frame
        pending_d       = accept ? 1'b1 : boundary ? 1'b0 : pending_q;
        shadow_plain_d  = accept ? upd_plain : shadow_plain_q;
        shadow_cipher_d = accept ? upd_cipher : shadow_cipher_q;
        act_plain_d     = boundary && pending_q ? shadow_plain_q : act_plain_q;
        act_cipher_d    = boundary && pending_q ? shadow_cipher_q : act_cipher_q;
        dec_code        = digit_q[1] ? act_plain_q : act_cipher_q;
        an_d            = (state_q == ST_BLANK || dark) ? 4'hF : ~(4'b0001 << digit_q);
        seg_d           = (state_q == ST_BLANK || dark) ? SEG_BLANK : digit_q[0] ? dec_tens : dec_units;
    end

`ifdef DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    logic [BW-1:0] blink_q, blink_d;
    logic          odd_q, odd_d;
    always_comb begin
        odd_d   = boundary ? !odd_q : odd_q;
        blink_d = boundary && pending_q ? BW'(BLINK_FRAMES) :
                  boundary && blink_q != '0 ? blink_q - BW'(1) : blink_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= '0;
            odd_q   <= 1'b0;
        end else begin
            blink_q <= blink_d;
            odd_q   <= odd_d;
        end
    end
    assign dark = blink_q != '0 && odd_q && !digit_q[1];
`else
    assign dark = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q      <= '0;
            digit_q         <= 2'd3;
            state_q         <= ST_BLANK;
            pending_q       <= 1'b0;
            shadow_plain_q  <= 5'd31;
            shadow_cipher_q <= 5'd31;
            act_plain_q     <= 5'd31;
            act_cipher_q    <= 5'd31;
            seg_q           <= SEG_BLANK;
            an_q            <= 4'hF;
        end else begin
            slot_cnt_q      <= slot_cnt_d;
            digit_q         <= digit_d;
            state_q         <= state_d;
            pending_q       <= pending_d;
            shadow_plain_q  <= shadow_plain_d;
            shadow_cipher_q <= shadow_cipher_d;
            act_plain_q     <= act_plain_d;
            act_cipher_q    <= act_cipher_d;
            seg_q           <= seg_d;
            an_q            <= an_d;
        end
    end

    assign upd_ready = !pending_q;
    assign seg       = seg_q;
    assign an        = an_q;
    assign dp        = 1'b1;
endmodule
